// File: rtl/marquee_scroller.sv
// marquee_scroller: scrolling-text engine for multi-digit 16-segment LED displays.
// A message RAM is read one character per scroll tick; the character is decoded by an
// external combinational ROM (ascii -> segments) and shifted into the digit register.
// Optional feature: define MARQUEE_BIDIR_EN to let the dir input select right shifts.
// Without it dir is ignored and the display always scrolls left.
module marquee_scroller #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MSG_DEPTH  = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DIV_W      = 23
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       dir,
    input  logic [DIV_W-1:0]           div,
    input  logic [ADDR_W:0]            msg_len,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [7:0]                 wr_data,
    output logic [7:0]                 ascii,
    input  logic [15:0]                segments,
    output logic [16*NUM_DIGITS-1:0]   digits,
    output logic                       wrap
);

    localparam int unsigned DigW = 16 * NUM_DIGITS;

    localparam logic [DIV_W-1:0]  DivMin   = DIV_W'(4);
    localparam logic [DIV_W-1:0]  DivOne   = DIV_W'(1);
    localparam logic [ADDR_W:0]   LenMax   = (ADDR_W + 1)'(MSG_DEPTH);
    localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);
    localparam logic [7:0]        AsciiRst = 8'h20;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StDecode = 2'd2,
        StShift  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  period_q, period_d;
    logic [DIV_W-1:0]  div_eff;
    logic              tick;

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W:0]   ptr_inc;
    logic              ptr_wraps;

    logic [7:0]        mem [MSG_DEPTH];
    logic [7:0]        rd_data_q;
    logic              rd_en;

    logic [7:0]        ascii_q, ascii_d;
    logic [DigW-1:0]   digits_q, digits_d;
    logic              wrap_q, wrap_d;

`ifndef MARQUEE_BIDIR_EN
    // dir has no effect in the left-only build.
    logic unused_dir;
    assign unused_dir = dir;
`endif

    // Prescaler: counts 0..div_eff-1 while enabled; the period is latched at count 0 so a
    // div change never truncates or stretches a period already in progress.
    always_comb begin
        div_eff  = (div < DivMin) ? DivMin : div;
        tick     = enable && (cnt_q == period_q - DivOne);
        cnt_d    = cnt_q;
        period_d = period_q;
        if (enable) begin
            if (cnt_q == '0) begin
                period_d = div_eff;
            end
            if (tick) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DivOne;
            end
        end
    end

    // Sequencer next state: one fetch/decode/shift pass per tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (tick) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: state_d = StShift;
            StShift:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Read pointer advance; a length at or below the pointer forces a wrap to 0.
    always_comb begin
        if (msg_len == '0) begin
            len_eff = LenOne;
        end else if (msg_len > LenMax) begin
            len_eff = LenMax;
        end else begin
            len_eff = msg_len;
        end
        ptr_inc   = {1'b0, ptr_q} + LenOne;
        ptr_wraps = (ptr_inc >= len_eff);
        ptr_d     = ptr_q;
        wrap_d    = 1'b0;
        if (state_q == StShift) begin
            wrap_d = ptr_wraps;
            ptr_d  = ptr_wraps ? '0 : ptr_inc[ADDR_W-1:0];
        end
    end

    // Character presented to the ROM: live RAM data in DECODE, otherwise held. The held
    // copy keeps segments stable through SHIFT.
    always_comb begin
        ascii_d = ascii_q;
        if (state_q == StDecode) begin
            ascii_d = rd_data_q;
        end
    end

    // Display register: shift the decoded pattern in during SHIFT.
    always_comb begin
        digits_d = digits_q;
        if (state_q == StShift) begin
`ifdef MARQUEE_BIDIR_EN
            if (dir) begin
                digits_d = (digits_q >> 16) | (DigW'(segments) << (DigW - 16));
            end else begin
                digits_d = (digits_q << 16) | DigW'(segments);
            end
`else
            digits_d = (digits_q << 16) | DigW'(segments);
`endif
        end
    end

    assign rd_en = (state_q == StFetch);

    // Message RAM: synchronous write, synchronous read-before-write, never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[ptr_q];
        end
    end

    // Control and display state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            period_q <= DivMin;
            ptr_q    <= '0;
            ascii_q  <= AsciiRst;
            digits_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            ptr_q    <= ptr_d;
            ascii_q  <= ascii_d;
            digits_q <= digits_d;
            wrap_q   <= wrap_d;
        end
    end

    assign ascii  = ascii_d;
    assign digits = digits_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_marquee_scroller.sv
// Self-checking bench for marquee_scroller: a cycle-level behavioural model of the scroll
// engine is checked against the DUT every cycle, plus hand-computed literal checks.
module tb_marquee_scroller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        dir = 1'b0;
    logic [22:0] div = 23'd8;
    logic [5:0]  msg_len = 6'd4;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  ascii;
    logic [15:0] segments;
    logic [63:0] digits;
    logic        wrap;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int dut_nwrap = 0;
    bit checking = 1'b0;

    // Character ROM stand-in: any injective, non-trivial mapping will do.
    function automatic logic [15:0] rom(input logic [7:0] c);
        return {c ^ 8'h5A, ~c};
    endfunction

    assign segments = rom(ascii);

    marquee_scroller dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .dir      (dir),
        .div      (div),
        .msg_len  (msg_len),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ascii    (ascii),
        .segments (segments),
        .digits   (digits),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural model: m_age counts cycles since the tick (1=fetch, 3=shift).
    logic [7:0]  m_mem [32];
    logic [63:0] m_digits = '0;
    logic [7:0]  m_ascii = 8'h20;
    logic [7:0]  m_char = 8'h20;
    logic        m_wrap = 1'b0;
    int          m_cnt = 0;
    int          m_per = 4;
    int          m_age = -1;
    int          m_ptr = 0;
    int          m_len;
    int          m_nshift = 0;
    bit          m_tick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_digits = '0;
            m_ascii  = 8'h20;
            m_wrap   = 1'b0;
            m_cnt    = 0;
            m_per    = 4;
            m_age    = -1;
            m_ptr    = 0;
        end else begin
            m_wrap = 1'b0;
            if (m_age == 1) begin
                m_char  = m_mem[m_ptr];
                m_ascii = m_char;
            end
            if (m_age == 3) begin
`ifdef MARQUEE_BIDIR_EN
                if (dir) m_digits = {rom(m_char), m_digits[63:16]};
                else     m_digits = {m_digits[47:0], rom(m_char)};
`else
                m_digits = {m_digits[47:0], rom(m_char)};
`endif
                m_len = (msg_len == 0) ? 1 : int'(msg_len);
                if (m_ptr + 1 >= m_len) begin
                    m_ptr  = 0;
                    m_wrap = 1'b1;
                end else begin
                    m_ptr = m_ptr + 1;
                end
                m_nshift++;
            end
            m_tick = 1'b0;
            if (enable) begin
                if (m_cnt == 0) m_per = (div < 4) ? 4 : int'(div);
                if (m_cnt == m_per - 1) begin
                    m_tick = 1'b1;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (m_age == 3)     m_age = -1;
            else if (m_age > 0) m_age++;
            if (m_tick) m_age = 1;
            if (wr_en) m_mem[wr_addr] = wr_data;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking && !rst) begin
            compared++;
            if (digits !== m_digits || ascii !== m_ascii || wrap !== m_wrap) begin
                mismatched++;
                if (mismatched <= 20)
                    $display("FAIL cycle %0d: got digits=%h ascii=%h wrap=%b, want digits=%h ascii=%h wrap=%b",
                             cyc, digits, ascii, wrap, m_digits, m_ascii, m_wrap);
            end
            if (wrap) dut_nwrap++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_age(input int a, input int budget);
        int n = 0;
        while (m_age != a && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_age != a) begin
            compared++;
            mismatched++;
            $display("FAIL wait_age: got age %0d want %0d", m_age, a);
        end
    endtask

    task automatic wait_shifts(input int cnt, input int budget);
        int target = m_nshift + cnt;
        int n = 0;
        while (m_nshift < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_nshift < target) begin
            compared++;
            mismatched++;
            $display("FAIL wait_shifts: got %0d shifts want %0d", m_nshift, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_a, t_b, nw0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_digits", 64'(digits), 64'h0);
        check("reset_ascii", 64'(ascii), 64'h20);
        check("reset_wrap", 64'(wrap), 64'h0);
        rst = 1'b0;
        checking = 1'b1;

        // Message "ABCDEFGH..." at addresses 0..31.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_data = 8'(8'h41 + i);
        end
        @(negedge clk);
        wr_en = 1'b0;

        // Basic scroll, div=8, msg_len=4, with latency pinned.
        div = 23'd8;
        msg_len = 6'd4;
        nw0 = dut_nwrap;
        enable = 1'b1;
        wait_age(1, 20);
        @(negedge clk);
        check("decode_ascii", 64'(ascii), 64'h41);
        check("decode_digits", digits, 64'h0);
        @(negedge clk);
        check("shift_digits", digits, 64'h0);
        @(negedge clk);
        check("first_update", digits, {48'h0, rom(8'h41)});
        wait_shifts(1, 20);
        t_a = cyc;
        wait_shifts(2, 40);
        t_b = cyc;
        check("period_div8", 64'(t_b - t_a), 64'd16);
        check("abcd_display", digits, {rom(8'h41), rom(8'h42), rom(8'h43), rom(8'h44)});
        #1;
        check("abcd_wraps", 64'(dut_nwrap - nw0), 64'd1);

        // Wrap with msg_len=3.
        enable = 1'b0;
        do_reset();
        msg_len = 6'd3;
        nw0 = dut_nwrap;
        enable = 1'b1;
        wait_shifts(2, 40);
        #1;
        check("no_early_wrap", 64'(dut_nwrap - nw0), 64'd0);
        wait_shifts(1, 20);
        check("wrap_pulse", 64'(wrap), 64'd1);
        @(negedge clk);
        check("wrap_one_cycle", 64'(wrap), 64'd0);
        wait_age(2, 20);
        check("fourth_fetch_addr0", 64'(ascii), 64'h41);

        // Clamp div=1 and msg_len=0.
        enable = 1'b0;
        do_reset();
        div = 23'd1;
        msg_len = 6'd0;
        nw0 = dut_nwrap;
        enable = 1'b1;
        wait_shifts(1, 20);
        t_a = cyc;
        wait_shifts(1, 20);
        t_b = cyc;
        check("period_clamped", 64'(t_b - t_a), 64'd4);
        wait_shifts(2, 20);
        check("repeat_char", digits, {4{rom(8'h41)}});
        #1;
        check("wrap_every_shift", 64'(dut_nwrap - nw0), 64'd4);

        // Enable dropped during FETCH.
        enable = 1'b0;
        do_reset();
        div = 23'd8;
        msg_len = 6'd8;
        enable = 1'b1;
        wait_shifts(2, 40);
        wait_age(1, 20);
        enable = 1'b0;
        wait_shifts(1, 10);
        check("drop_completes", digits, {16'h0, rom(8'h41), rom(8'h42), rom(8'h43)});
        repeat (100) @(negedge clk);
        check("frozen_100", digits, {16'h0, rom(8'h41), rom(8'h42), rom(8'h43)});

        // Shrink msg_len below ptr (ptr=5 after two more shifts).
        enable = 1'b1;
        wait_shifts(2, 40);
        msg_len = 6'd2;
        wait_shifts(1, 20);
        check("shrink_wrap", 64'(wrap), 64'd1);
        check("shrink_char", 64'(digits[15:0]), 64'(rom(8'h46)));
        wait_age(2, 20);
        check("shrink_refetch0", 64'(ascii), 64'h41);

        // Direction with "AB".
        enable = 1'b0;
        do_reset();
        div = 23'd4;
        msg_len = 6'd2;
        dir = 1'b1;
        enable = 1'b1;
        wait_shifts(2, 20);
`ifdef MARQUEE_BIDIR_EN
        check("dir_right", digits, {rom(8'h42), rom(8'h41), 32'h0});
`else
        check("dir_ignored", digits, {32'h0, rom(8'h41), rom(8'h42)});
`endif
        dir = 1'b0;

        // Asynchronous reset in the middle of DECODE.
        wait_age(2, 20);
        rst = 1'b1;
        #1;
        check("rst_mid_digits", digits, 64'h0);
        check("rst_mid_ascii", 64'(ascii), 64'h20);
        check("rst_mid_wrap", 64'(wrap), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_age(2, 20);
        check("post_rst_addr0", 64'(ascii), 64'h41);

        enable = 1'b0;
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
